// File: rtl/instr_mem_ctrl_if.sv
// instr_mem_ctrl_if: fetch, loader, memory-port and power signals of the instruction memory controller.
interface instr_mem_ctrl_if;
   logic        fetch_req;
   logic [14:0] fetch_addr;
   logic        fetch_gnt;
   logic        fetch_rvalid;
   logic [31:0] fetch_rdata;
   logic        load_req;
   logic [14:0] load_addr;
   logic [31:0] load_wdata;
   logic [7:0]  load_mask;
   logic        load_gnt;
   logic        pwr_off_req;
   logic [14:0] mem_addr;
   logic [31:0] mem_data_in;
   logic [7:0]  mem_mask_wren;
   logic        mem_wren;
   logic        mem_chip_sel;
   logic [31:0] mem_data_out;
   logic        mem_standby;
   logic        mem_sleep;
   logic        mem_poweroff;
   logic [2:0]  pwr_state;
   logic        contents_lost;
   modport slave (
      input  fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_mask, pwr_off_req, mem_data_out,
      output fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, mem_addr, mem_data_in, mem_mask_wren,
             mem_wren, mem_chip_sel, mem_standby, mem_sleep, mem_poweroff, pwr_state, contents_lost
   );
   modport master (
      output fetch_req, fetch_addr, load_req, load_addr, load_wdata, load_mask, pwr_off_req, mem_data_out,
      input  fetch_gnt, fetch_rvalid, fetch_rdata, load_gnt, mem_addr, mem_data_in, mem_mask_wren,
             mem_wren, mem_chip_sel, mem_standby, mem_sleep, mem_poweroff, pwr_state, contents_lost
   );
endinterface

// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: round-robin fetch/loader arbiter for the instruction memory port
// with an idle-driven standby/sleep/poweroff sequencer.
module instr_mem_ctrl #(
   parameter int IDLE_STANDBY = 16,
   parameter int IDLE_SLEEP   = 256,
   parameter int WAKE_CYCLES  = 3
) (
   input logic             clk,
   input logic             reset,
   instr_mem_ctrl_if.slave bus
);
   localparam int IW = $clog2(IDLE_SLEEP + 1);
   localparam int WW = $clog2(WAKE_CYCLES + 1);
   localparam logic [IW-1:0] STBY_N  = IW'(IDLE_STANDBY);
   localparam logic [IW-1:0] SLEEP_N = IW'(IDLE_SLEEP);
   localparam logic [WW-1:0] WAKE_N  = WW'(WAKE_CYCLES);
   typedef enum logic [2:0] {ACTIVE = 3'd0, STANDBY = 3'd1, SLEEP = 3'd2, WAKE = 3'd3, OFF = 3'd4} pwr_e;
   pwr_e          state_q, state_d;
   logic [IW-1:0] idle_q, idle_d;
   logic [WW-1:0] wake_q, wake_d;
   logic          rr_q, rr_d;
   logic          rvalid_q, lost_q;
   logic          any_req, f_gnt, l_gnt;
   // rr_q=1 means the loader was granted last, so fetch wins the next tie
   assign any_req = bus.fetch_req | bus.load_req;
   assign f_gnt   = state_q == ACTIVE && bus.fetch_req && (!bus.load_req || rr_q);
   assign l_gnt   = state_q == ACTIVE && bus.load_req && !(bus.fetch_req && rr_q);
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ACTIVE;
         idle_q   <= '0;
         wake_q   <= '0;
         rr_q     <= 1'b1;
         rvalid_q <= 1'b0;
         lost_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idle_q   <= idle_d;
         wake_q   <= wake_d;
         rr_q     <= rr_d;
         rvalid_q <= f_gnt;
         lost_q   <= lost_q | (state_d == OFF);
      end
   end
   always_comb begin
      state_d = state_q;
      wake_d  = wake_q;
      rr_d    = (f_gnt | l_gnt) ? l_gnt : rr_q;
      idle_d  = (f_gnt | l_gnt) ? '0 :
                (state_q == WAKE || state_q == OFF) ? '0 :
                (idle_q == SLEEP_N) ? idle_q : idle_q + 1'b1;
      // an issued fetch must deliver its read data before the memory powers off
      if (bus.pwr_off_req && !f_gnt) begin
         state_d = OFF;
      end else begin
         case (state_q)
            ACTIVE:  state_d = (!any_req && idle_q >= STBY_N) ? STANDBY : ACTIVE;
            STANDBY: begin
               state_d = any_req ? WAKE : (idle_q >= SLEEP_N) ? SLEEP : STANDBY;
               wake_d  = any_req ? WW'(1) : wake_q;
            end
            SLEEP: begin
               state_d = any_req ? WAKE : SLEEP;
               wake_d  = any_req ? WAKE_N : wake_q;
            end
            WAKE: begin
               state_d = (wake_q <= WW'(1)) ? ACTIVE : WAKE;
               wake_d  = wake_q - 1'b1;
            end
            OFF: begin
               state_d = WAKE;
               wake_d  = WAKE_N;
            end
            default: state_d = ACTIVE;
         endcase
      end
   end
   always_comb begin
      bus.fetch_gnt     = f_gnt;
      bus.load_gnt      = l_gnt;
      bus.fetch_rvalid  = rvalid_q;
      bus.fetch_rdata   = rvalid_q ? bus.mem_data_out : '0;
      bus.mem_chip_sel  = f_gnt | l_gnt;
      bus.mem_wren      = l_gnt;
      bus.mem_addr      = f_gnt ? bus.fetch_addr : l_gnt ? bus.load_addr : '0;
      bus.mem_data_in   = l_gnt ? bus.load_wdata : '0;
      bus.mem_mask_wren = l_gnt ? bus.load_mask : '0;
      bus.mem_standby   = state_q == STANDBY;
      bus.mem_sleep     = state_q == SLEEP;
      bus.mem_poweroff  = state_q == OFF;
      bus.pwr_state     = state_q;
      bus.contents_lost = lost_q;
   end
endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Sequencing and arbitration controller in front of the two-bank 32 KiW instruction memory. It shares the single memory port between the CPU fetch path and the program loader, with round-robin arbitration and at most one access per cycle. It also drives the memory's shared standby/sleep/poweroff pins from an idle-driven power state machine. It sits between the fetch unit/loader and the instruction memory.

## Interface
- IDLE_STANDBY, default 16: consecutive idle ACTIVE cycles before entering STANDBY. Must be ≥1.
- IDLE_SLEEP, default 256: consecutive idle cycles, counted from the last grant, before entering SLEEP. Must be > IDLE_STANDBY.
- WAKE_CYCLES, default 3: WAKE dwell after SLEEP or OFF. Must be ≥1.
- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  fetch read request. Held with fetch_addr stable until fetch_gnt.
- fetch_addr  in  15  fetch word address.
- fetch_gnt  out  1  one-cycle pulse: the fetch access is issued this cycle.
- fetch_rvalid  out  1  fetch_rdata valid. Asserted the cycle after fetch_gnt.
- fetch_rdata  out  32  read data. Equals mem_data_out when fetch_rvalid=1, else 0.
- load_req  in  1  loader write request. Held until load_gnt.
- load_addr  in  15  loader word address.
- load_wdata  in  32  write data.
- load_mask  in  8  write nibble mask.
- load_gnt  out  1  one-cycle pulse: the write is issued this cycle.
- pwr_off_req  in  1  level. While high, the memory is powered off.
- mem_addr  out  15, mem_data_in  out  32, mem_mask_wren  out  8, mem_wren  out  1, mem_chip_sel  out  1: memory port.
- mem_data_out  in  32  memory read data. Valid one cycle after a read issue.
- mem_standby, mem_sleep, mem_poweroff  out  1 each: active-high power controls to memory.
- pwr_state  out  3  ACTIVE=0, STANDBY=1, SLEEP=2, WAKE=3, OFF=4.
- contents_lost  out  1  sticky. Set on OFF entry; cleared only by reset.

## Operation
- Reset values:
  - All gnt/rvalid/mem_* outputs are 0. fetch_rdata=0 and contents_lost=0.
  - pwr_state=ACTIVE, idle counter 0, wake counter 0.
  - Round-robin pointer = "loader last", so fetch wins the first tie.
- Arbitration happens in ACTIVE only, and is combinational in the same cycle.
  - If exactly one req is high, grant it.
  - If both are high, grant the requester not granted last. The pointer updates on every grant.
- Grant cycle drives:
  - mem_chip_sel=1 and mem_addr = the granted requester's address.
  - For a loader grant: mem_wren=1, mem_data_in=load_wdata, mem_mask_wren=load_mask.
  - For a fetch grant: mem_wren=0 and mem_mask_wren=0.
  - In non-grant cycles all mem_* data/control outputs are 0.
- fetch_rvalid is registered from fetch_gnt. Back-to-back fetch grants give back-to-back rvalids.
- Idle counter:
  - Resets to 0 on any grant.
  - Otherwise increments in ACTIVE, STANDBY and SLEEP, saturating at IDLE_SLEEP. Width is clog2(IDLE_SLEEP+1).
- Power FSM:
  - ACTIVE → STANDBY when the counter reaches IDLE_STANDBY with no req. Sets mem_standby=1.
  - STANDBY → SLEEP when the counter reaches IDLE_SLEEP with no req. Sets mem_sleep=1 and mem_standby=0.
  - STANDBY with any req → WAKE, wake count 1.
  - SLEEP with any req → WAKE, wake count WAKE_CYCLES.
  - WAKE: all power pins 0. Counts down to 0, then → ACTIVE.
  - Any state with pwr_off_req=1 → OFF, once no rvalid is pending. Sets mem_poweroff=1 and contents_lost=1.
  - OFF with pwr_off_req=0 → WAKE, wake count WAKE_CYCLES.
- Boundary conditions:
  - A req in the same cycle the idle threshold is reached: the grant wins and no transition occurs.
  - pwr_off_req in a grant cycle: the grant completes, the rvalid is delivered, then OFF.
  - pwr_off_req has priority over wake.
  - No grant is issued outside ACTIVE. Requests stay pending, unlost.
  - Reset mid-access: the next cycle has rvalid=0, state ACTIVE, no grant. Any outstanding read is dropped.

## Timing
- Latency from req to gnt:
  - In ACTIVE: 0 cycles (same cycle).
  - From STANDBY: req seen at t, WAKE at t+1, grant at t+2.
  - From SLEEP or OFF exit: grant at t+1+WAKE_CYCLES.
- Read data is valid exactly 1 cycle after gnt.
- Throughput is 1 access per cycle. With continuous contention, grants alternate fetch/load.
- Power pins change on the clock edge following the state decision. At most one power pin is high at any time.

## Test plan
- Reset, then fetch_req at addr 0x0010 with memory returning 0xDEADBEEF → fetch_gnt in the same cycle; next cycle fetch_rvalid=1 and fetch_rdata=0xDEADBEEF.
- fetch_req and load_req held high for 6 cycles → grants F,L,F,L,F,L. Loader grants show mem_wren=1, load_mask passed through, and addr 0x4000 (bank 1) forwarded unchanged.
- No requests for 16 cycles → pwr_state=1 and mem_standby=1. At 256 idle cycles → pwr_state=2 and mem_sleep=1. A fetch_req then → gnt exactly 4 cycles later (WAKE_CYCLES=3).
- A fetch_req on the exact cycle the idle count reaches 16 → granted with no STANDBY entry, and the counter clears to 0.
- pwr_off_req asserted during a fetch grant → rvalid delivered, then OFF with mem_poweroff=1 and contents_lost=1. Requests get no grant until release, then WAKE lasts 3 cycles before the first grant.
- Reset asserted the cycle after a fetch grant → fetch_rvalid=0, all outputs at reset values, contents_lost cleared.
